program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have a clock input clk and an asynchronous, active-high reset input named reset.
REQ-002 The ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  rising-edge clock.
- reset  in  1  async active-high reset.
- in_valid  in  1  load-stream byte valid.
- in_data  in  8  load-stream byte.
- in_ready  out  1  loader accepts byte this cycle.
- load_req  in  1  pulse that restarts loading from RUN/ERROR.
- mem_addr  out  8  program-memory write address.
- mem_wdata  out  8  program-memory write data.
- mem_we  out  1  program-memory write enable, 1 cycle per byte.
- cpu_hold  out  1  active-high hold/reset driven into the CPU.
- done  out  1  program loaded; CPU released.
- err  out  1  load failed (checksum mismatch).
REQ-003 All outputs SHALL be registered; in_ready SHALL be decoded from state only and SHALL not depend on in_valid.

Function
REQ-004 A byte SHALL transfer on a rising clk edge where in_valid && in_ready are both 1; in_data is ignored otherwise.
REQ-005 States SHALL be IDLE, LOAD, CHECK, DRAIN, RUN and ERROR; in_ready=1 only in IDLE, LOAD and CHECK.
REQ-006 IDLE: the first accepted byte is the length header N; N=0 SHALL mean 256 bytes; next state LOAD.
REQ-007 LOAD: the k-th accepted data byte (k=0..N-1) SHALL produce mem_we=1, mem_addr=k, mem_wdata=byte in the cycle after acceptance.
REQ-008 The byte counter SHALL be 9 bits so that N=256 ends at address 255 without wrapping to 0; no address above N-1 SHALL be written.
REQ-009 After the final data byte is accepted: the next state SHALL be CHECK if PROGRAM_LOADER_CHECKSUM_EN is defined, and DRAIN otherwise.
REQ-010 DRAIN SHALL last exactly one cycle, then go to RUN.
REQ-011 The memory write for the final data byte SHALL be visible before cpu_hold falls.
REQ-012 cpu_hold SHALL fall and done SHALL rise in the first RUN cycle, which is 2 cycles after the final data byte is accepted, or 2 cycles after an accepted matching checksum.
REQ-013 RUN: cpu_hold=0, done=1, no memory writes; a load_req=1 sample SHALL return to IDLE with cpu_hold=1 and done=0 on the next cycle.
REQ-014 ERROR: cpu_hold=1, err=1, done=0; only load_req or reset SHALL leave it, and load_req SHALL clear err and go to IDLE.
REQ-015 load_req in IDLE, LOAD, CHECK or DRAIN SHALL be ignored.
REQ-016 Outside single write cycles, mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.

Reset
REQ-017 Asserting reset SHALL force IDLE, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0 and byte counter=0 immediately.
REQ-018 Reset mid-LOAD SHALL abandon the transfer with no further writes; the next accepted byte SHALL be treated as a new header.

Configuration
REQ-019 Macro PROGRAM_LOADER_CHECKSUM_EN defined: a checksum byte SHALL follow the N data bytes, and CHECK accepts that one byte.
REQ-020 The expected checksum SHALL be the 8-bit wrapping sum of the N data bytes (header excluded); match -> DRAIN, mismatch -> ERROR.
REQ-021 Macro undefined: the CHECK state, the checksum accumulator and err logic SHALL be absent, and err SHALL be tied to 0.

Verification
REQ-022 Header 0x03, data 0x13,0x36,0xF0 back-to-back -> writes (0,0x13),(1,0x36),(2,0xF0) on consecutive cycles; done=1 and cpu_hold=0 2 cycles after 0xF0 is accepted (no macro).
REQ-023 Header 0x00, then 256 bytes with value=index -> addr 255 written with 0xFF, no write to addr 0 after addr 255, done=1.
REQ-024 Header 0x02, data 0x80,0x90, with in_valid toggling every cycle -> exactly 2 writes, addrs 0 and 1, with no duplicates.
REQ-025 With the macro, header 0x02, data 0x80,0x90, checksum 0x10 -> done=1; checksum 0x11 -> err=1, cpu_hold=1; then load_req -> IDLE with err=0.
REQ-026 Reset asserted after 2 of 5 data bytes -> outputs at reset values at once; new header 0x01 plus data 0xAA -> single write (0,0xAA), done=1.
REQ-027 In RUN, pulse load_req -> cpu_hold=1 and done=0 next cycle; in_ready=1.

Source files
------------

// File: rtl/program_loader.sv
// Boot loader: streams a length-prefixed program image into program memory while holding the CPU.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte; a mismatch parks in ERROR.
module program_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       load_req,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       cpu_hold,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        RUN   = 3'd3
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        CHECK = 3'd4,
        ERROR = 3'd5
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] count_q, count_d;
    logic [8:0] len_q, len_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic       mem_we_q, mem_we_d;
    logic       cpu_hold_q, cpu_hold_d;
    logic       done_q, done_d;
    logic       accept;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       err_q, err_d;
`endif

    // Ready is a pure state decode so a source may wait on it before raising valid.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign in_ready = (state_q == IDLE) || (state_q == LOAD) || (state_q == CHECK);
`else
    assign in_ready = (state_q == IDLE) || (state_q == LOAD);
`endif
    assign accept = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        len_d       = len_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    count_d = 9'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = count_q[7:0];
                    mem_wdata_d = in_data;
                    count_d     = count_q + 9'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + in_data;
                    if (count_q == len_q - 9'd1) state_d = CHECK;
`else
                    if (count_q == len_q - 9'd1) state_d = DRAIN;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) state_d = (in_data == sum_q) ? DRAIN : ERROR;
            end
            ERROR: begin
                if (load_req) state_d = IDLE;
            end
`endif
            // One settling cycle lets the final memory write land before the CPU is released.
            DRAIN: state_d = RUN;
            RUN: begin
                if (load_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cpu_hold_d = (state_d != RUN);
        done_d     = (state_d == RUN);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        err_d      = (state_d == ERROR);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 9'd0;
            len_q       <= 9'd0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= 8'd0;
            mem_we_q    <= 1'b0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q       <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            len_q       <= len_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
            err_q       <= err_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus random load streams
// compared every cycle against a transaction-level model of the loader.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       load_req = 1'b0;
    logic       in_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       cpu_hold;
    logic       done;
    logic       err;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    program_loader dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .load_req (load_req),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int n_timeouts = 0;
    int cyc = 0;

    logic [15:0] wlog[$];
    int          wcyc[$];
    logic [7:0]  mem_img [256];

    // Model state: what the stream expects next, not how the DUT encodes it.
    bit         m_hdr;
    int         m_rem;
    bit         m_ck;
    int         m_rel;
    bit         m_run;
    bit         m_fail;
    int         m_idx;
    logic [7:0] m_sum;
    logic       exp_we;
    logic [7:0] exp_addr;
    logic [7:0] exp_wdata;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic bit model_ready();
        return !(m_rel > 0 || m_run || m_fail);
    endfunction

    task automatic model_reset();
        m_hdr = 1'b1; m_rem = 0; m_ck = 1'b0; m_rel = 0; m_run = 1'b0; m_fail = 1'b0;
        m_idx = 0; m_sum = 8'd0;
        exp_we = 1'b0; exp_addr = 8'd0; exp_wdata = 8'd0;
    endtask

    task automatic model_step();
        bit         rdy;
        bit         lr;
        bit         v;
        logic [7:0] d;
        rdy = model_ready();
        lr  = load_req;
        v   = in_valid;
        d   = in_data;
        exp_we = 1'b0;
        if (m_run && lr) begin
            m_run = 1'b0; m_hdr = 1'b1;
        end else if (m_fail && lr) begin
            m_fail = 1'b0; m_hdr = 1'b1;
        end
        if (m_rel > 0) begin
            m_rel--;
            if (m_rel == 0) m_run = 1'b1;
        end
        if (v && rdy) begin
            if (m_hdr) begin
                m_hdr = 1'b0;
                m_rem = (d == 8'd0) ? 256 : int'(d);
                m_idx = 0;
                m_sum = 8'd0;
            end else if (m_rem > 0) begin
                exp_we    = 1'b1;
                exp_addr  = m_idx[7:0];
                exp_wdata = d;
                m_idx++;
                m_sum = m_sum + d;
                m_rem--;
                if (m_rem == 0) begin
                    if (CK_EN) m_ck = 1'b1;
                    else       m_rel = 1;
                end
            end else if (m_ck) begin
                m_ck = 1'b0;
                if (d == m_sum) m_rel = 1;
                else            m_fail = 1'b1;
            end
        end
    endtask

    // Model advance and per-cycle comparison share one process so they cannot race.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_reset();
            end else begin
                model_step();
                #1;
                if (!reset) begin
                    cyc++;
                    checkOutput("in_ready",  32'(in_ready),  32'(model_ready()));
                    checkOutput("mem_we",    32'(mem_we),    32'(exp_we));
                    checkOutput("mem_addr",  32'(mem_addr),  32'(exp_addr));
                    checkOutput("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
                    checkOutput("cpu_hold",  32'(cpu_hold),  32'(!m_run));
                    checkOutput("done",      32'(done),      32'(m_run));
                    checkOutput("err",       32'(err),       32'(m_fail));
                    if (mem_we) begin
                        wlog.push_back({mem_addr, mem_wdata});
                        wcyc.push_back(cyc);
                        mem_img[mem_addr] = mem_wdata;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic lr);
        in_valid = v;
        in_data  = d;
        load_req = lr;
        @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] d);
        int tries = 0;
        bit ok = 1'b0;
        if (n_timeouts > 3) return;
        while (!ok && tries < 50) begin
            ok = in_ready;
            applyStimulus(1'b1, d, 1'b0);
            tries++;
        end
        in_valid = 1'b0;
        load_req = 1'b0;
        if (!ok) begin
            n_timeouts++;
            checkOutput("accept_timeout", 32'(ok), 32'd1);
        end
    endtask

    task automatic sendChecksum(input logic [7:0] s);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sendByte(s);
`else
        if (CK_EN) sendByte(s);
`endif
    endtask

    task automatic doReset(input string tag);
        in_valid = 1'b0;
        load_req = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput({tag, "_rst_we"},    32'(mem_we),    32'd0);
        checkOutput({tag, "_rst_addr"},  32'(mem_addr),  32'd0);
        checkOutput({tag, "_rst_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({tag, "_rst_hold"},  32'(cpu_hold),  32'd1);
        checkOutput({tag, "_rst_done"},  32'(done),      32'd0);
        checkOutput({tag, "_rst_err"},   32'(err),       32'd0);
        checkOutput({tag, "_rst_ready"}, 32'(in_ready),  32'd1);
        @(negedge clk);
        reset = 1'b0;
        wlog.delete();
        wcyc.delete();
    endtask

    initial begin
        logic [7:0] sum;
        logic [7:0] d;
        int         n;
        bit         aborted;
        repeat (2) @(negedge clk);
        doReset("por");

        // Three-byte image back to back; release two cycles after the last byte.
        sendByte(8'h03);
        sendByte(8'h13);
        sendByte(8'h36);
        sendByte(8'hF0);
        checkOutput("r22_last_we",    32'(mem_we),    32'd1);
        checkOutput("r22_last_addr",  32'(mem_addr),  32'd2);
        checkOutput("r22_last_wdata", 32'(mem_wdata), 32'hF0);
        checkOutput("r22_hold_still", 32'(cpu_hold),  32'd1);
        sendChecksum(8'h39);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("r22_done",  32'(done),     32'd1);
        checkOutput("r22_hold",  32'(cpu_hold), 32'd0);
        checkOutput("r22_nwr",   32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            checkOutput("r22_w0", 32'(wlog[0]), 32'h0013);
            checkOutput("r22_w1", 32'(wlog[1]), 32'h0136);
            checkOutput("r22_w2", 32'(wlog[2]), 32'h02F0);
            checkOutput("r22_consec", 32'(wcyc[2] - wcyc[0]), 32'd2);
        end

        // load_req from RUN puts the CPU back into hold and reopens the stream.
        applyStimulus(1'b0, 8'h00, 1'b1);
        load_req = 1'b0;
        checkOutput("r27_hold",  32'(cpu_hold), 32'd1);
        checkOutput("r27_done",  32'(done),     32'd0);
        checkOutput("r27_ready", 32'(in_ready), 32'd1);

        // Header 0 means a full 256-byte image ending at address 255.
        wlog.delete(); wcyc.delete();
        sendByte(8'h00);
        for (int i = 0; i < 256; i++) sendByte(8'(i));
        sendChecksum(8'h80);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("r23_nwr",   32'(wlog.size()), 32'd256);
        checkOutput("r23_m255",  32'(mem_img[255]), 32'hFF);
        if (wlog.size() > 0) checkOutput("r23_lastw", 32'(wlog[wlog.size() - 1]), 32'hFFFF);
        checkOutput("r23_done",  32'(done), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Gappy valid: writes must not repeat while valid is low.
        wlog.delete(); wcyc.delete();
        sendByte(8'h02);
        applyStimulus(1'b0, 8'h55, 1'b0);
        sendByte(8'h80);
        applyStimulus(1'b0, 8'h55, 1'b0);
        sendByte(8'h90);
        applyStimulus(1'b0, 8'h55, 1'b0);
        sendChecksum(8'h10);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("r24_nwr", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            checkOutput("r24_w0", 32'(wlog[0]), 32'h0080);
            checkOutput("r24_w1", 32'(wlog[1]), 32'h0190);
        end
        checkOutput("r24_done", 32'(done), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        doReset("r25a");
        sendByte(8'h02); sendByte(8'h80); sendByte(8'h90); sendByte(8'h11);
        checkOutput("r25_err",   32'(err),      32'd1);
        checkOutput("r25_hold",  32'(cpu_hold), 32'd1);
        checkOutput("r25_done",  32'(done),     32'd0);
        applyStimulus(1'b1, 8'h02, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("r25_stuck", 32'(err),      32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        load_req = 1'b0;
        checkOutput("r25_clr",   32'(err),      32'd0);
        checkOutput("r25_ready", 32'(in_ready), 32'd1);
`endif

        // Reset mid-image abandons it; the next byte is a fresh header.
        doReset("r26a");
        sendByte(8'h05); sendByte(8'h01); sendByte(8'h02);
        doReset("r26b");
        sendByte(8'h01); sendByte(8'hAA);
        sendChecksum(8'hAA);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("r26_nwr", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) checkOutput("r26_w0", 32'(wlog[0]), 32'h00AA);
        checkOutput("r26_done", 32'(done), 32'd1);

        // Random images with gaps, stray load_req pulses, bad sums and mid-load resets.
        doReset("rnd");
        for (int t = 0; t < 30; t++) begin
            aborted = 1'b0;
            n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 10);
            sendByte(8'(n));
            sum = 8'd0;
            for (int k = 0; k < ((n == 0) ? 256 : n); k++) begin
                if ($urandom_range(0, 2) == 0)
                    applyStimulus(1'b0, 8'($urandom), ($urandom_range(0, 3) == 0));
                d = 8'($urandom);
                sendByte(d);
                sum = sum + d;
                if (t % 8 == 5 && k == 0) begin
                    doReset("rnd_mid");
                    aborted = 1'b1;
                    break;
                end
            end
            if (aborted) continue;
            sendChecksum(($urandom_range(0, 3) == 0) ? sum + 8'd1 : sum);
            repeat ($urandom_range(1, 4)) applyStimulus(1'($urandom), 8'($urandom), 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b1);
            applyStimulus(1'b0, 8'h00, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
